// File: rtl/dsram_pkg.sv
// Shared types and constants for the data-SRAM arbiter.
package dsram_pkg;

    localparam int unsigned DSRAM_DW = 32;
    localparam int unsigned DSRAM_NB = 4;
    localparam int unsigned RUN_CW   = 4;

    typedef enum logic {
        OWN_LSU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    typedef struct packed {
        logic [31:0]         addr;
        logic                we;
        logic [DSRAM_NB-1:0] be;
        logic [DSRAM_DW-1:0] wdata;
    } dsram_req_t;

endpackage

// File: rtl/dsram_arb_grant.sv
// Grant selection between LSU and DMA.
// Default: LSU priority with a starvation guard. Defining DSRAM_ARB_RR_EN
// switches to strict round-robin.
module dsram_arb_grant
    import dsram_pkg::*;
#(
    parameter int unsigned MAX_LSU_RUN = 4
) (
    input  logic clk,
    input  logic cpurst_n,
    input  logic lsu_valid,
    input  logic dma_valid,
    output logic gnt_lsu,
    output logic gnt_dma
);

    if (MAX_LSU_RUN < 1 || MAX_LSU_RUN > 15) begin : g_bad_run
        $error("MAX_LSU_RUN must be in 1..15");
    end

`ifdef DSRAM_ARB_RR_EN

    owner_e last_q;
    owner_e last_d;

    // Alternate when both request; remember the most recent grant.
    always_comb begin
        gnt_lsu = 1'b0;
        gnt_dma = 1'b0;
        last_d  = last_q;
        if (lsu_valid && dma_valid) begin
            if (last_q == OWN_DMA) gnt_lsu = 1'b1;
            else                   gnt_dma = 1'b1;
        end else begin
            gnt_lsu = lsu_valid;
            gnt_dma = dma_valid;
        end
        if (gnt_lsu)      last_d = OWN_LSU;
        else if (gnt_dma) last_d = OWN_DMA;
    end

    // Last-grant register.
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) last_q <= OWN_DMA;
        else           last_q <= last_d;
    end

`else

    localparam logic [RUN_CW-1:0] RUN_MAX = RUN_CW'(MAX_LSU_RUN);

    logic [RUN_CW-1:0] run_q;
    logic [RUN_CW-1:0] run_d;

    // LSU wins unless it has already held DMA off for MAX_LSU_RUN grants.
    always_comb begin
        gnt_lsu = lsu_valid && !((run_q == RUN_MAX) && dma_valid);
        gnt_dma = dma_valid && !gnt_lsu;
        run_d   = run_q;
        if (!dma_valid || gnt_dma)            run_d = '0;
        else if (gnt_lsu && run_q != RUN_MAX) run_d = run_q + RUN_CW'(1);
    end

    // Consecutive-LSU-grant counter while DMA waits.
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) run_q <= '0;
        else           run_q <= run_d;
    end

`endif

endmodule

// File: rtl/dsram_arbiter.sv
// Data-SRAM arbiter: one access per cycle, one-cycle read latency,
// responses routed back to the granted requester.
// Optional build macro: DSRAM_ARB_RR_EN (round-robin instead of LSU priority).
module dsram_arbiter
    import dsram_pkg::*;
#(
    parameter int unsigned MEM_AW      = 10,
    parameter int unsigned MAX_LSU_RUN = 4
) (
    input  logic                clk,
    input  logic                cpurst_n,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [31:0]         lsu_req_addr,
    input  logic                lsu_req_we,
    input  logic [DSRAM_NB-1:0] lsu_req_be,
    input  logic [DSRAM_DW-1:0] lsu_req_wdata,
    output logic                lsu_rsp_valid,
    output logic [DSRAM_DW-1:0] lsu_rsp_rdata,
    input  logic                dma_req_valid,
    output logic                dma_req_ready,
    input  logic [31:0]         dma_req_addr,
    input  logic                dma_req_we,
    input  logic [DSRAM_NB-1:0] dma_req_be,
    input  logic [DSRAM_DW-1:0] dma_req_wdata,
    output logic                dma_rsp_valid,
    output logic [DSRAM_DW-1:0] dma_rsp_rdata,
    output logic                sram_cs,
    output logic                sram_we,
    output logic [DSRAM_NB-1:0] sram_be,
    output logic [MEM_AW-1:0]   sram_addr,
    output logic [DSRAM_DW-1:0] sram_wdata,
    input  logic [DSRAM_DW-1:0] sram_rdata
);

    logic       gnt_lsu;
    logic       gnt_dma;
    dsram_req_t gnt_req;
    logic       rsp_valid_q;
    owner_e     rsp_owner_q;
    logic       rsp_rd_q;
    logic       unused_addr_bits;

    dsram_arb_grant #(
        .MAX_LSU_RUN (MAX_LSU_RUN)
    ) u_grant (
        .clk       (clk),
        .cpurst_n  (cpurst_n),
        .lsu_valid (lsu_req_valid),
        .dma_valid (dma_req_valid),
        .gnt_lsu   (gnt_lsu),
        .gnt_dma   (gnt_dma)
    );

    assign lsu_req_ready = gnt_lsu;
    assign dma_req_ready = gnt_dma;

    // Select the granted payload; all-zero when nothing is granted.
    always_comb begin
        gnt_req = '0;
        if (gnt_lsu)      gnt_req = '{addr: lsu_req_addr, we: lsu_req_we, be: lsu_req_be, wdata: lsu_req_wdata};
        else if (gnt_dma) gnt_req = '{addr: dma_req_addr, we: dma_req_we, be: dma_req_be, wdata: dma_req_wdata};
    end

    assign sram_cs    = gnt_lsu | gnt_dma;
    assign sram_we    = gnt_req.we;
    assign sram_be    = gnt_req.be;
    assign sram_addr  = gnt_req.addr[MEM_AW+1:2];
    assign sram_wdata = gnt_req.wdata;

    // Byte offset and bits above the array alias away.
    assign unused_addr_bits = ^{gnt_req.addr[31:MEM_AW+2], gnt_req.addr[1:0]};

    // Response tracking: who owns the access in flight and whether it reads.
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= OWN_LSU;
            rsp_rd_q    <= 1'b0;
        end else begin
            rsp_valid_q <= sram_cs;
            rsp_owner_q <= gnt_dma ? OWN_DMA : OWN_LSU;
            rsp_rd_q    <= sram_cs && !sram_we;
        end
    end

    assign lsu_rsp_valid = rsp_valid_q && (rsp_owner_q == OWN_LSU);
    assign dma_rsp_valid = rsp_valid_q && (rsp_owner_q == OWN_DMA);
    assign lsu_rsp_rdata = (lsu_rsp_valid && rsp_rd_q) ? sram_rdata : '0;
    assign dma_rsp_rdata = (dma_rsp_valid && rsp_rd_q) ? sram_rdata : '0;

endmodule
